// File: rtl/restoring_div_seq_if.sv
// Start/done handshake bundle for restoring_div_seq: operands in, results and status out.
interface restoring_div_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/restoring_div_seq.sv
// Sequential unsigned restoring divider: one shared subtractor, WIDTH iterations per result.
// Optional feature macro DIV_ZERO_DETECT_EN: divisor 0 short-circuits straight to DONE.
module restoring_div_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  restoring_div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   d;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;

  // A's top bit is always 0 after a restore, so only WIDTH bits are stored;
  // the shifted partial remainder and the difference keep the full WIDTH+1 bits.
  always_comb begin
    a_sh   = {a, q[WIDTH-1]};
    d      = a_sh + ~{1'b0, m} + {{WIDTH{1'b0}}, 1'b1};
    a_next = d[WIDTH] ? a_sh[WIDTH-1:0] : d[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], ~d[WIDTH]};
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dbz;
  assign bus.div_by_zero = dbz;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dbz         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            a      <= '0;
            q      <= bus.dividend;
            m      <= bus.divisor;
            cnt    <= CW'(WIDTH);
            state  <= RUN;
            busy_r <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
            dbz    <= 1'b0;
            if (bus.divisor == '0) begin
              state       <= DONE;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              cnt         <= '0;
              quotient_r  <= '1;
              remainder_r <= bus.dividend;
              dbz         <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            quotient_r  <= q_next;
            remainder_r <= a_next;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
endmodule
